// File: rtl/freq_meas_scheduler.sv
// Round-robin scheduler sharing one period detector across NUM_CH comparator channels.
// Emits one {channel, period, timeout} result per measurement on a valid/ready stream.
module freq_meas_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int COUNTER_WIDTH  = 18,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [COUNTER_WIDTH-1:0] det_period,
    input  logic                     det_stable,
    output logic                     det_clr,
    output logic [CH_W-1:0]          ch_sel,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CH_W-1:0]          res_ch,
    output logic [COUNTER_WIDTH-1:0] res_period,
    output logic                     res_timeout
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = (TO_W > ST_W) ? TO_W : ST_W;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_WAIT,
        S_EMIT,
        S_NEXT
    } state_t;

    state_t                   r_state;
    logic [CH_W-1:0]          r_cur_ch;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_det_clr;
    logic [CH_W-1:0]          r_ch_sel;
    logic                     r_busy;
    logic                     r_res_valid;
    logic [CH_W-1:0]          r_res_ch;
    logic [COUNTER_WIDTH-1:0] r_res_period;
    logic                     r_res_timeout;

    logic [CH_W-1:0] w_pick;
    logic [CH_W-1:0] w_idx;
    logic            w_found;
    logic            w_go;

    // Scan cur_ch+1 upward with wrap; cur_ch itself is the last candidate.
    always_comb begin
        w_pick  = r_cur_ch;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_W'((int'(r_cur_ch) + i) % NUM_CH);
            if (!w_found && ch_mask[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_go = enable && (|ch_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur_ch      <= CH_W'(NUM_CH - 1);
            r_cnt         <= '0;
            r_det_clr     <= 1'b1;
            r_ch_sel      <= '0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_period  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_NEXT: begin
                    if (w_go) begin
                        r_cur_ch  <= w_pick;
                        r_ch_sel  <= w_pick;
                        r_det_clr <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_det_clr <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_det_clr <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A stable reading on the last timer cycle still counts.
                    if (det_stable) begin
                        r_res_ch      <= r_cur_ch;
                        r_res_period  <= det_period;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_EMIT;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_res_ch      <= r_cur_ch;
                        r_res_period  <= '0;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_EMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_NEXT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign det_clr     = r_det_clr;
    assign ch_sel      = r_ch_sel;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_period  = r_res_period;
    assign res_timeout = r_res_timeout;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Bench for freq_meas_scheduler: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_freq_meas_scheduler;

    localparam int NUM_CH = 4;
    localparam int CW     = 18;
    localparam int SET    = 16;
    localparam int TO     = 1000;
    localparam int CH_W   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic [3:0]      ch_mask = 4'b0;
    logic [CW-1:0]   det_period = '0;
    logic            det_stable = 1'b0;
    logic            res_ready = 1'b1;
    logic            det_clr;
    logic [CH_W-1:0] ch_sel;
    logic            busy;
    logic            res_valid;
    logic [CH_W-1:0] res_ch;
    logic [CW-1:0]   res_period;
    logic            res_timeout;

    freq_meas_scheduler #(
        .NUM_CH(NUM_CH),
        .COUNTER_WIDTH(CW),
        .SETTLE_CYCLES(SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ch_mask(ch_mask),
        .det_period(det_period),
        .det_stable(det_stable),
        .det_clr(det_clr),
        .ch_sel(ch_sel),
        .busy(busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_ch(res_ch),
        .res_period(res_period),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;
    bit chk_on = 1'b0;

    int mode = 2;
    bit s_val = 1'b0;
    bit rdy_rand = 1'b0;
    bit r_val = 1'b1;

    typedef struct {
        int ch;
        int per;
        int to;
    } res_t;
    res_t rq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        tcyc++;
    end

    // Detector and consumer stand-ins.
    initial forever begin
        @(posedge clk);
        #3;
        det_period = CW'(200 * (int'(ch_sel) + 1));
        case (mode)
            0: det_stable = 1'b0;
            1: begin
                det_stable = ($urandom_range(0, 15) == 0);
                det_period = det_period + CW'($urandom_range(0, 7));
            end
            2: det_stable = 1'b1;
            default: det_stable = s_val;
        endcase
        res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : r_val;
    end

    // Reference model: measurement timeline expressed as cycle stamps.
    localparam int P_IDLE = 0;
    localparam int P_MEAS = 1;
    localparam int P_EMIT = 2;
    localparam int P_GAP  = 3;

    int m_ph = P_IDLE;
    int m_cur = NUM_CH - 1;
    int m_sel = 0;
    int m_clr = -100;
    int m_cyc = 0;
    int m_rch = 0;
    int m_rper = 0;
    int m_rto = 0;
    bit m_rclr = 1'b1;

    function automatic int next_ch(input int cur, input logic [3:0] m);
        int r;
        r = cur;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (m[(cur + k) % NUM_CH]) r = (cur + k) % NUM_CH;
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ph = P_IDLE;
            m_cur = NUM_CH - 1;
            m_sel = 0;
            m_clr = -100;
            m_rch = 0;
            m_rper = 0;
            m_rto = 0;
            m_rclr = 1'b1;
        end else begin
            m_cyc++;
            case (m_ph)
                P_IDLE, P_GAP: begin
                    if (enable && ch_mask != 4'b0) begin
                        m_cur = next_ch(m_cur, ch_mask);
                        m_sel = m_cur;
                        m_clr = m_cyc;
                        m_ph = P_MEAS;
                    end else begin
                        m_ph = P_IDLE;
                    end
                end
                P_MEAS: begin
                    if (m_cyc - 1 >= m_clr + 1 + SET) begin
                        if (det_stable) begin
                            m_rch = m_cur;
                            m_rper = int'(det_period);
                            m_rto = 0;
                            m_ph = P_EMIT;
                        end else if (m_cyc - 1 == m_clr + SET + TO) begin
                            m_rch = m_cur;
                            m_rper = 0;
                            m_rto = 1;
                            m_ph = P_EMIT;
                        end
                    end
                end
                default: begin
                    if (res_ready) m_ph = P_GAP;
                end
            endcase
            m_rclr = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("det_clr", det_clr, m_rclr || (m_ph == P_MEAS && m_cyc == m_clr));
            chk("busy", busy, m_ph != P_IDLE);
            chk("ch_sel", ch_sel, m_sel);
            chk("res_valid", res_valid, m_ph == P_EMIT);
            chk("res_ch", res_ch, m_rch);
            chk("res_period", res_period, m_rper);
            chk("res_timeout", res_timeout, m_rto);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && res_valid && res_ready)
            rq.push_back('{int'(res_ch), int'(res_period), int'(res_timeout)});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_sig(input string nm, input int which, input int lim);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < lim && !ok; n++) begin
            step();
            case (which)
                0: ok = res_valid;
                1: ok = !busy;
                default: ok = det_clr;
            endcase
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: condition not reached within %0d cycles", nm, lim);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int h;
        #1 rst = 1'b1;
        #1 chk_on = 1'b1;
        repeat (3) step();
        chk("rst_det_clr", det_clr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_ch_sel", ch_sel, 0);
        rst = 1'b0;
        step();
        chk("idle_det_clr", det_clr, 0);

        // Round-robin over 4'b1011 with stable readings.
        rq.delete();
        mode = 2;
        ch_mask = 4'b1011;
        enable = 1'b1;
        for (int n = 0; n < 2000 && rq.size() < 5; n++) step();
        chk("t1_count", (rq.size() >= 5), 1);
        if (rq.size() >= 5) begin
            chk("t1_ch0", rq[0].ch, 0);
            chk("t1_ch1", rq[1].ch, 1);
            chk("t1_ch2", rq[2].ch, 3);
            chk("t1_ch3", rq[3].ch, 0);
            chk("t1_ch4", rq[4].ch, 1);
            chk("t1_per0", rq[0].per, 200);
            chk("t1_per1", rq[1].per, 400);
            chk("t1_per2", rq[2].per, 800);
            chk("t1_per4", rq[4].per, 400);
            chk("t1_to2", rq[2].to, 0);
        end
        enable = 1'b0;
        wait_sig("t1_idle", 1, 200);

        // Pure timeout on a single channel.
        mode = 0;
        ch_mask = 4'b0100;
        enable = 1'b1;
        k = tcyc;
        wait_sig("t2_valid", 0, 1200);
        chk("t2_latency", tcyc - k, 1018);
        chk("t2_ch", res_ch, 2);
        chk("t2_period", res_period, 0);
        chk("t2_timeout", res_timeout, 1);
        wait_sig("t2_reclr", 2, 10);
        chk("t2_resel", ch_sel, 2);
        mode = 2;
        enable = 1'b0;
        wait_sig("t2_idle", 1, 200);

        // Backpressure in EMIT.
        ch_mask = 4'b1111;
        r_val = 1'b0;
        enable = 1'b1;
        wait_sig("t3_valid", 0, 100);
        for (int n = 0; n < 500; n++) begin
            chk("t3_valid_hold", res_valid, 1);
            chk("t3_ch_hold", res_ch, 3);
            chk("t3_per_hold", res_period, 800);
            chk("t3_sel_hold", ch_sel, 3);
            chk("t3_no_clr", det_clr, 0);
            step();
        end
        r_val = 1'b1;
        h = tcyc;
        step();
        chk("t3_next_clr", det_clr, 0);
        chk("t3_drop", res_valid, 0);
        step();
        chk("t3_clr_at2", det_clr, 1);
        chk("t3_clr_delay", tcyc - h, 2);
        chk("t3_wrap_sel", ch_sel, 0);
        enable = 1'b0;
        wait_sig("t3_idle", 1, 200);

        // Stable during SETTLE ignored; stable on the timeout cycle wins.
        mode = 3;
        s_val = 1'b1;
        ch_mask = 4'b0001;
        enable = 1'b1;
        repeat (18) step();
        chk("t4_settle_ignored", res_valid, 0);
        s_val = 1'b0;
        repeat (999) step();
        chk("t4_no_early", res_valid, 0);
        s_val = 1'b1;
        step();
        chk("t4_valid", res_valid, 1);
        chk("t4_timeout", res_timeout, 0);
        chk("t4_period", res_period, 200);
        s_val = 1'b0;
        enable = 1'b0;
        wait_sig("t4_idle", 1, 200);

        // Enable drop mid-measurement, resume, and empty mask.
        ch_mask = 4'b1111;
        enable = 1'b1;
        repeat (30) step();
        enable = 1'b0;
        repeat (5) step();
        s_val = 1'b1;
        wait_sig("t5_valid", 0, 50);
        chk("t5_ch", res_ch, 1);
        s_val = 1'b0;
        wait_sig("t5_idle", 1, 20);
        repeat (3) step();
        chk("t5_stay_idle", busy, 0);
        chk("t5_no_clr", det_clr, 0);
        mode = 2;
        enable = 1'b1;
        wait_sig("t5_valid2", 0, 100);
        chk("t5_resume_ch", res_ch, 2);
        enable = 1'b0;
        wait_sig("t5_idle2", 1, 200);
        ch_mask = 4'b0;
        enable = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            chk("t5_mask0_clr", det_clr, 0);
            chk("t5_mask0_busy", busy, 0);
        end
        enable = 1'b0;

        // Async reset in SETTLE and in EMIT.
        ch_mask = 4'b1010;
        enable = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("t6_clr_settle", det_clr, 1);
        chk("t6_busy_settle", busy, 0);
        repeat (2) step();
        rst = 1'b0;
        wait_sig("t6_clr1", 2, 10);
        chk("t6_first_pick", ch_sel, 1);
        r_val = 1'b0;
        wait_sig("t6_valid", 0, 100);
        chk("t6_res_ch", res_ch, 1);
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", res_valid, 0);
        chk("t6_clr_emit", det_clr, 1);
        step();
        rst = 1'b0;
        r_val = 1'b1;
        wait_sig("t6_clr2", 2, 10);
        chk("t6_first_pick2", ch_sel, 1);
        enable = 1'b0;
        wait_sig("t6_idle", 1, 200);

        // Randomized soak against the model.
        rdy_rand = 1'b1;
        mode = 1;
        ch_mask = 4'($urandom_range(1, 15));
        enable = 1'b1;
        for (int n = 0; n < 15000; n++) begin
            step();
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) begin
                ch_mask = 4'($urandom_range(0, 15));
                mode = ($urandom_range(0, 19) == 0) ? 0 : 1;
            end
        end
        mode = 2;
        enable = 1'b0;
        wait_sig("t7_idle", 1, 3000);
        rdy_rand = 1'b0;
        step();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
